// File: rtl/axis_if.sv
// axis_if: AXI-Stream handshake bundle (tvalid/tready/tdata) of parameterised width.
// Latency: none; plain wires.
// Backpressure: tready flows from slave to master; m drives tvalid/tdata, s drives tready.
interface axis_if #(
  parameter int WIDTH = 32
) ();
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_downsizer.sv
// axis_downsizer: splits each IN_WIDTH input beat into RATIO OUT_WIDTH beats, least-significant lane first.
// Latency: first narrow beat is valid the cycle after the wide handshake, then one narrow beat per cycle.
// Backpressure: axis_sif.tready is combinational from axis_mif.tready; a new word is taken as the last lane leaves.
// Ports: clk; rst_n (async, active-low); axis_sif (wide input, slave); axis_mif (narrow output, master);
//        flush (drops the held word when AXIS_DOWNSIZER_FLUSH_EN is defined, ignored otherwise).
module axis_downsizer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  axis_if.s    axis_sif,
  axis_if.m    axis_mif,
  input  logic flush
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
    $error("axis_downsizer: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [IN_WIDTH-1:0]                buf_q;
  logic                               buf_load;
  logic [RATIO-1:0][OUT_WIDTH-1:0]    lanes;
  logic                               full_q;
  logic                               last;
  logic                               m_hs;
  logic                               s_hs;
  logic                               flush_act;

`ifdef AXIS_DOWNSIZER_FLUSH_EN
  assign flush_act = flush;
`else
  // Port kept so instantiations match across builds; it has no effect here.
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  // The held word viewed as lanes, lane 0 in the least-significant bits.
  assign lanes  = buf_q;
  assign full_q = (state_q == DRAIN);
  assign last   = (idx_q == LAST_IDX);

  assign axis_mif.tvalid = full_q;
  assign axis_mif.tdata  = lanes[idx_q];

  assign m_hs = axis_mif.tvalid && axis_mif.tready;
  // Accepting while the last lane leaves gives back-to-back words with no bubble.
  assign axis_sif.tready = !flush_act && (!full_q || (m_hs && last));
  assign s_hs = axis_sif.tvalid && axis_sif.tready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    buf_load = 1'b0;
    if (flush_act) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (s_hs) begin
      state_d  = DRAIN;
      idx_d    = '0;
      buf_load = 1'b1;
    end else if (m_hs && last) begin
      state_d = EMPTY;
      idx_d   = '0;
    end else if (m_hs) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (buf_load) begin
      buf_q <= axis_sif.tdata;
    end
  end

endmodule

// File: doc/axis_downsizer.md
# axis_downsizer

Width-reducing AXI-Stream stage that sits directly downstream of `axis_skid_buffer`. It accepts one IN_WIDTH-bit beat and emits it as RATIO = IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit beats, least-significant lane first. Its primary use is in the fetch path, where it splits 64-bit fetch blocks into 32-bit instruction words for the decode stream. The upstream skid buffer breaks the `tready` timing path, so this block is allowed to drive `axis_sif.tready` combinationally from `axis_mif.tready`.

## Interface
- IN_WIDTH, 64, width of the `axis_sif` tdata; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, width of the `axis_mif` tdata.
- RATIO (localparam) = IN_WIDTH/OUT_WIDTH; must be >= 2. Any other value is an elaboration error (`$error`).
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- axis_sif  axis_if.s  IN_WIDTH  wide input stream: tvalid, tready, tdata.
- axis_mif  axis_if.m  OUT_WIDTH  narrow output stream: tvalid, tready, tdata.
- flush  input  1  drops any held beat; only active when the configuration macro is defined.

## Operation
- State registers:
  - `buf_q[IN_WIDTH-1:0]`: the held wide word.
  - `full_q`: set while a held word has lanes left to emit.
  - `idx_q[$clog2(RATIO)-1:0]`: index of the next lane to emit.
- Outputs:
  - `axis_mif.tvalid = full_q`.
  - `axis_mif.tdata = buf_q[idx_q*OUT_WIDTH +: OUT_WIDTH]`.
- `last = (idx_q == RATIO-1)`.
- `m_hs = axis_mif.tvalid && axis_mif.tready`.
- `axis_sif.tready = !full_q || (m_hs && last)`. A new word may be accepted in the same cycle the last lane leaves, giving zero bubble.
- `s_hs = axis_sif.tvalid && axis_sif.tready`.
- Each cycle, evaluated in priority order:
  - flush (if enabled): `full_q <= 0` and `idx_q <= 0`; `axis_sif.tready` is forced to 0 this cycle.
  - s_hs: `buf_q <= axis_sif.tdata`, `full_q <= 1`, `idx_q <= 0`.
  - m_hs && last: `full_q <= 0`, `idx_q <= 0`.
  - m_hs: `idx_q <= idx_q + 1`.
  - otherwise: hold all state.
- Two-state behaviour:
  - EMPTY (`full_q=0`) goes to DRAIN on s_hs.
  - DRAIN stays in DRAIN while not at the last lane or when s_hs coincides with the last lane.
  - DRAIN goes to EMPTY on m_hs && last with no s_hs.
- `idx_q` never exceeds RATIO-1. When RATIO is a power of two, it wraps naturally.
- `axis_mif.tdata` must stay stable while tvalid=1 and tready=0. `buf_q` and `idx_q` change only on handshakes or flush.

## Timing
- Reset values:
  - `full_q=0`, `idx_q=0`, `buf_q=0`.
  - Hence `axis_mif.tvalid=0` and `axis_mif.tdata=0`.
  - `axis_sif.tready=1` from the first cycle after reset deasserts.
- Latency: the first narrow beat is valid in the cycle after s_hs. One narrow beat per cycle under continuous tready.
- Throughput: with no back-pressure, one wide beat is accepted every RATIO cycles and the output is 100% utilised.
- Reset asserted mid-drain: remaining lanes are discarded and tvalid drops immediately, asynchronously.
- Back-pressure on the last lane: `axis_sif.tready` stays 0 until that lane handshakes.

## Configuration
- Macro: `AXIS_DOWNSIZER_FLUSH_EN`.
- Defined:
  - `flush` is honoured with top priority, per Operation.
  - A flush that coincides with s_hs is impossible, because tready is forced to 0.
  - A flush that coincides with m_hs completes that narrow beat downstream, but the remainder of the word is dropped.
- Undefined:
  - The `flush` port still exists, so instantiations are identical, but it is ignored.
  - No flush logic is synthesised.

## Test plan
- Reset release with s_tvalid=0 -> m_tvalid=0, m_tdata=0, s_tready=1.
- Send 0x1111_2222_3333_4444 with m_tready=1 -> output 0x3333_4444 then 0x1111_2222 on consecutive cycles; s_tready=1 in the second cycle.
- Back-to-back input of 0xA..A then 0xB..B, m_tready=1 -> four consecutive output beats AAAAAAAA, AAAAAAAA, BBBBBBBB, BBBBBBBB with no bubble.
- m_tready=0 for 5 cycles while holding lane 0 -> tdata stable at the lane-0 value; s_tready=0; after release, lanes are emitted in order.
- With FLUSH_EN, assert flush while idx_q=1 and m_tready=0 -> next cycle m_tvalid=0 and s_tready=1; the lane is never emitted.
- Assert rst_n=0 mid-drain, then release -> m_tvalid=0 immediately; the next input starts at lane 0.
